ddr3_wr_control: RTL and testbench

//   Downstream of adc_acq_top, in the adc_clk domain. Buffers 128-bit header/ADC words
//   (adc_acq_out_dat/valid) in a small FIFO and writes them to consecutive DDR3 addresses

---
 rtl/ddr3_wr_pkg.sv | 19 +
 rtl/ddr3_wr_fifo.sv | 56 +++++
 rtl/ddr3_wr_control.sv | 158 +++++++++++++++
 tb/tb_ddr3_wr_control.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_wr_pkg.sv
// Shared types for the DDR3 write path: FSM encoding, MIG command code, word width.
// Optional DDR3_WR_CHECKSUM_EN uses word_fold() for the running checksum.
package ddr3_wr_pkg;

  localparam int WORD_W = 128;
  localparam logic [2:0] APP_CMD_WR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STORE,
    ST_FLUSH,
    ST_DONE
  } wr_state_t;

  function automatic logic [31:0] word_fold(input logic [WORD_W-1:0] d);
    return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
  endfunction

endpackage

// File: rtl/ddr3_wr_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is valid whenever !empty.
// A pop in the same cycle frees a slot, so push on full+pop is accepted.
module ddr3_wr_fifo
  import ddr3_wr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = WORD_W,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ddr3_wr_control.sv
// Buffers acquisition words and writes them to consecutive DDR3 addresses via MIG.
// `define DDR3_WR_CHECKSUM_EN adds the wr_checksum output.
module ddr3_wr_control
  import ddr3_wr_pkg::*;
#(
  parameter int              FIFO_DEPTH = 16,
  parameter int              ADDR_W     = 28,
  parameter int              ADDR_INC   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              adc_clk,
  input  logic              acq_reset,
  input  logic [127:0]      adc_acq_out_dat,
  input  logic              adc_acq_out_valid,
  input  logic              acq_done,
  input  logic              readout_done,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic [127:0]      app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              ddr3_wr_done,
  output logic [23:0]       words_written,
`ifdef DDR3_WR_CHECKSUM_EN
  output logic [31:0]       wr_checksum,
`endif
  output logic              fifo_overflow,
  output logic              addr_wrap
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_t         state_q;
  wr_state_t         state_d;
  logic              xfer_q;
  logic              cmd_ok_q;
  logic              dat_ok_q;
  logic              commit;
  logic              push_req;
  logic              push_ok;
  logic              rearm;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [127:0]      head;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   addr_sum;
  logic [23:0]       words_q;
  logic              ovf_q;
  logic              wrap_q;

  assign commit   = xfer_q & (cmd_ok_q | app_rdy)
                  & (dat_ok_q | app_wdf_rdy);
  assign push_req = adc_acq_out_valid & (state_q != ST_DONE);
  assign push_ok  = push_req & (~fifo_full | commit);
  assign rearm    = (state_q == ST_DONE) & readout_done;
  assign addr_sum = {1'b0, addr_q} + (ADDR_W+1)'(ADDR_INC);

  ddr3_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (adc_clk),
    .rst   (acq_reset),
    .push  (push_req),
    .pop   (commit),
    .din   (adc_acq_out_dat),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge adc_clk) begin
    if (acq_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (adc_acq_out_valid)          state_d = ST_STORE;
        else if (acq_done & fifo_empty) state_d = ST_DONE;
      end
      ST_STORE: if (acq_done) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (fifo_empty & ~xfer_q & ~push_ok) state_d = ST_DONE;
      end
      ST_DONE:  if (readout_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command and data halves of a write may be accepted in different cycles.
  always_ff @(posedge adc_clk) begin
    if (acq_reset) begin
      xfer_q   <= 1'b0;
      cmd_ok_q <= 1'b0;
      dat_ok_q <= 1'b0;
    end else if (!xfer_q) begin
      xfer_q   <= ~fifo_empty;
      cmd_ok_q <= 1'b0;
      dat_ok_q <= 1'b0;
    end else if (commit) begin
      xfer_q   <= (fifo_count > CW'(1)) | push_ok;
      cmd_ok_q <= 1'b0;
      dat_ok_q <= 1'b0;
    end else begin
      cmd_ok_q <= cmd_ok_q | app_rdy;
      dat_ok_q <= dat_ok_q | app_wdf_rdy;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (acq_reset || rearm) begin
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      ovf_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (push_req && !push_ok) ovf_q <= 1'b1;
      if (commit) begin
        addr_q <= addr_sum[ADDR_W-1:0];
        if (addr_sum[ADDR_W]) wrap_q <= 1'b1;
        if (words_q != '1) words_q <= words_q + 24'd1;
      end
    end
  end

`ifdef DDR3_WR_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge adc_clk) begin
    if (acq_reset || rearm)
      sum_q <= '0;
    else if (commit && state_q != ST_DONE)
      sum_q <= sum_q + word_fold(head);
  end

  assign wr_checksum = sum_q;
`endif

  assign app_en        = xfer_q & ~cmd_ok_q;
  assign app_wdf_wren  = xfer_q & ~dat_ok_q;
  assign app_wdf_end   = app_wdf_wren;
  assign app_cmd       = APP_CMD_WR;
  assign app_addr      = addr_q;
  assign app_wdf_data  = xfer_q ? head : '0;
  assign ddr3_wr_done  = (state_q == ST_DONE);
  assign words_written = words_q;
  assign fifo_overflow = ovf_q;
  assign addr_wrap     = wrap_q;

endmodule

// File: tb/tb_ddr3_wr_control.sv
// Directed bench for ddr3_wr_control with a write scoreboard.
// Build with DDR3_WR_CHECKSUM_EN to also exercise wr_checksum.
module tb_ddr3_wr_control;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic         clk;
  logic         acq_reset;
  logic [127:0] dat;
  logic         valid;
  logic         acq_done;
  logic         readout_done;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         ddr3_wr_done;
  logic [23:0]  words_written;
  logic         fifo_overflow;
  logic         addr_wrap;
`ifdef DDR3_WR_CHECKSUM_EN
  logic [31:0]  wr_checksum;
  logic [31:0]  w_checksum;
`endif

  logic [127:0] w_dat;
  logic         w_valid;
  logic         w_app_en;
  logic [2:0]   w_app_cmd;
  logic [5:0]   w_app_addr;
  logic [127:0] w_app_wdf_data;
  logic         w_app_wdf_wren;
  logic         w_app_wdf_end;
  logic         w_done;
  logic [23:0]  w_words;
  logic         w_ovf;
  logic         w_wrap;

  int total = 0;
  int failed = 0;
  wr_t exp_q[$];
  logic [27:0]  cq[$];
  logic [127:0] dq[$];
  logic [27:0]  exp_addr;

  ddr3_wr_control u_dut (
    .adc_clk           (clk),
    .acq_reset         (acq_reset),
    .adc_acq_out_dat   (dat),
    .adc_acq_out_valid (valid),
    .acq_done          (acq_done),
    .readout_done      (readout_done),
    .app_rdy           (app_rdy),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .ddr3_wr_done      (ddr3_wr_done),
    .words_written     (words_written),
`ifdef DDR3_WR_CHECKSUM_EN
    .wr_checksum       (wr_checksum),
`endif
    .fifo_overflow     (fifo_overflow),
    .addr_wrap         (addr_wrap)
  );

  ddr3_wr_control #(
    .ADDR_W    (6),
    .BASE_ADDR (6'd56)
  ) u_wrap (
    .adc_clk           (clk),
    .acq_reset         (acq_reset),
    .adc_acq_out_dat   (w_dat),
    .adc_acq_out_valid (w_valid),
    .acq_done          (1'b0),
    .readout_done      (1'b0),
    .app_rdy           (1'b1),
    .app_wdf_rdy       (1'b1),
    .app_en            (w_app_en),
    .app_cmd           (w_app_cmd),
    .app_addr          (w_app_addr),
    .app_wdf_data      (w_app_wdf_data),
    .app_wdf_wren      (w_app_wdf_wren),
    .app_wdf_end       (w_app_wdf_end),
    .ddr3_wr_done      (w_done),
    .words_written     (w_words),
`ifdef DDR3_WR_CHECKSUM_EN
    .wr_checksum       (w_checksum),
`endif
    .fifo_overflow     (w_ovf),
    .addr_wrap         (w_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input bit accept);
    valid = 1'b1;
    dat   = d;
    if (accept) begin
      exp_q.push_back('{addr: exp_addr, data: d});
      exp_addr = exp_addr + 28'd8;
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !ddr3_wr_done; i++) tick();
    check("done_reached", ddr3_wr_done, 1'b1);
  endtask

  task automatic rearm();
    acq_done     = 1'b0;
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    exp_addr     = 28'd0;
    check("rearm_done", ddr3_wr_done, 1'b0);
    check("rearm_words", words_written, 24'd0);
    check("rearm_addr", app_addr, 28'd0);
    check("rearm_ovf", fifo_overflow, 1'b0);
  endtask

  // Pair accepted command and data beats and compare to the scoreboard.
  always @(negedge clk) begin
    if (acq_reset) begin
      cq.delete();
      dq.delete();
    end else begin
      if (app_en && app_rdy) cq.push_back(app_addr);
      if (app_wdf_wren && app_wdf_rdy) dq.push_back(app_wdf_data);
      if (cq.size() > 0 && dq.size() > 0) begin
        logic [27:0]  a;
        logic [127:0] d;
        wr_t          e;
        a = cq.pop_front();
        d = dq.pop_front();
        if (exp_q.size() == 0) begin
          check("extra_write", 128'(exp_q.size()), 128'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", a, e.addr);
          check("wr_data", d, e.data);
        end
      end
    end
  end

  initial begin
    acq_reset    = 1'b1;
    dat          = '0;
    valid        = 1'b0;
    acq_done     = 1'b0;
    readout_done = 1'b0;
    app_rdy      = 1'b0;
    app_wdf_rdy  = 1'b0;
    w_dat        = '0;
    w_valid      = 1'b0;
    exp_addr     = 28'd0;
    tick(); tick(); tick();

    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_end", app_wdf_end, 1'b0);
    check("rst_cmd", app_cmd, 3'b000);
    check("rst_addr", app_addr, 28'd0);
    check("rst_data", app_wdf_data, 128'd0);
    check("rst_done", ddr3_wr_done, 1'b0);
    check("rst_words", words_written, 24'd0);
    check("rst_ovf", fifo_overflow, 1'b0);
    check("rst_wrap", addr_wrap, 1'b0);
    check("rst_w_addr", w_app_addr, 6'd56);
    acq_reset = 1'b0;

    // Basic fill with MIG always ready
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    send(128'hA000_0001_0000_0000_1111_2222_3333_4444, 1'b1);
    send(128'hB000_0002_FFFF_0000_5555_6666_7777_8888, 1'b1);
    send(128'hC000_0003_1234_5678_9ABC_DEF0_0F0F_F0F0, 1'b1);
    acq_done = 1'b1;
    wait_done(50);
    check("t1_words", words_written, 24'd3);
    check("t1_sb_empty", 128'(exp_q.size()), 128'd0);
    rearm();

    // Command stalled, data accepted early
    app_rdy = 1'b0;
    send(128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_en_held", app_en, 1'b1);
      check("t2_data_held", app_wdf_data,
            128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002);
      check("t2_no_pop", words_written, 24'd0);
      tick();
    end
    app_rdy  = 1'b1;
    tick();
    acq_done = 1'b1;
    wait_done(50);
    check("t2_words", words_written, 24'd1);
    check("t2_sb_empty", 128'(exp_q.size()), 128'd0);
    rearm();

    // Overflow: 20 words into a 16-deep FIFO with MIG stalled
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    for (int i = 0; i < 20; i++)
      send({32'h5A5A_0000 + 32'(i), 96'(i * 7 + 1)}, i < 16);
    tick();
    check("t3_ovf", fifo_overflow, 1'b1);
    check("t3_words_stalled", words_written, 24'd0);
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    acq_done    = 1'b1;
    wait_done(100);
    check("t3_words", words_written, 24'd16);
    check("t3_sb_empty", 128'(exp_q.size()), 128'd0);
    rearm();

    // Address wrap on the 6-bit instance
    w_valid = 1'b1;
    w_dat   = 128'h77;
    tick();
    w_valid = 1'b0;
    tick();
    check("t4_en0", w_app_en, 1'b1);
    check("t4_addr0", w_app_addr, 6'd56);
    check("t4_wrap0", w_wrap, 1'b0);
    tick();
    w_valid = 1'b1;
    w_dat   = 128'h88;
    tick();
    w_valid = 1'b0;
    tick();
    check("t4_en1", w_app_en, 1'b1);
    check("t4_addr1", w_app_addr, 6'd0);
    check("t4_data1", w_app_wdf_data, 128'h88);
    tick();
    check("t4_wrap", w_wrap, 1'b1);
    check("t4_words", w_words, 24'd2);

    // Reset mid-transfer, then re-arm and refill
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    send(128'h1111, 1'b1);
    send(128'h2222, 1'b1);
    tick();
    check("t5_en_before", app_en, 1'b1);
    acq_reset = 1'b1;
    exp_q.delete();
    tick();
    acq_reset = 1'b0;
    check("t5_en", app_en, 1'b0);
    check("t5_wren", app_wdf_wren, 1'b0);
    check("t5_addr", app_addr, 28'd0);
    check("t5_words", words_written, 24'd0);
    check("t5_done", ddr3_wr_done, 1'b0);
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    exp_addr     = 28'd0;
    app_rdy      = 1'b1;
    app_wdf_rdy  = 1'b1;
    send(128'h3333_0000_4444, 1'b1);
    acq_done = 1'b1;
    wait_done(50);
    check("t5_words_after", words_written, 24'd1);
    check("t5_sb_empty", 128'(exp_q.size()), 128'd0);
    rearm();

`ifdef DDR3_WR_CHECKSUM_EN
    send(128'h1, 1'b1);
    send(128'h2_0000_0000, 1'b1);
    acq_done = 1'b1;
    wait_done(50);
    check("t6_checksum", wr_checksum, 32'h3);
    rearm();
    check("t6_checksum_clr", wr_checksum, 32'h0);
`endif

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
